// File: rtl/wb_stage_if.sv
// MEM/WB boundary bundle: MEM-stage fields and data-memory read response in,
// register-file write port, back-pressure and retire counter out.
interface wb_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_rfwr;
   logic [4:0]      in_rd;
   logic [1:0]      in_wdsel;
   logic [2:0]      in_ldtype;
   logic [XLEN-1:0] in_alu;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic            stall_req;
   logic            RFWr;
   logic [4:0]      WrDtAdr;
   logic [XLEN-1:0] WrDt;
   logic [31:0]     instret;

   // Upstream pipeline / memory side
   modport master (
      output in_valid, in_rfwr, in_rd, in_wdsel, in_ldtype, in_alu, in_pc,
             flush, mem_rvalid, mem_rdata,
      input  stall_req, RFWr, WrDtAdr, WrDt, instret
   );

   // Write-back stage side
   modport slave (
      input  in_valid, in_rfwr, in_rd, in_wdsel, in_ldtype, in_alu, in_pc,
             flush, mem_rvalid, mem_rdata,
      output stall_req, RFWr, WrDtAdr, WrDt, instret
   );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, result select, load extension,
// late-load wait with back-pressure, and retired-instruction counter.
module wb_stage #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   wb_stage_if.slave  bus
);
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] READY = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;

   logic [1:0]      state;
   logic            heldRfwr;
   logic [4:0]      heldRd;
   logic [1:0]      heldWdsel;
   logic [2:0]      heldLdtype;
   logic [XLEN-1:0] heldAlu;
   logic [XLEN-1:0] heldPc;
   logic [31:0]     instretQ;

   logic            stallReq;
   logic            retire;
   logic [XLEN-1:0] byteLane;
   logic [XLEN-1:0] halfLane;
   logic [XLEN-1:0] ldData;
   logic [XLEN-1:0] wrData;

   // A held instruction leaves when it is ready, or when its load data shows up
   assign retire   = (state == READY) | ((state == WAIT) & bus.mem_rvalid);
   assign stallReq = (state == WAIT) & ~bus.mem_rvalid;

   // Stage register: capture whenever not back-pressuring; flush beats valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= EMPTY;
         heldRfwr   <= 1'b0;
         heldRd     <= '0;
         heldWdsel  <= '0;
         heldLdtype <= '0;
         heldAlu    <= '0;
         heldPc     <= '0;
      end else if (!stallReq) begin
         if (!bus.in_valid || bus.flush)   state <= EMPTY;
         else if (bus.in_wdsel == SEL_LOAD) state <= WAIT;
         else                               state <= READY;
         heldRfwr   <= bus.in_rfwr;
         heldRd     <= bus.in_rd;
         heldWdsel  <= bus.in_wdsel;
         heldLdtype <= bus.in_ldtype;
         heldAlu    <= bus.in_alu;
         heldPc     <= bus.in_pc;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        instretQ <= '0;
      else if (retire) instretQ <= instretQ + 32'd1;
   end

   // Align the addressed byte / halfword down to bit 0
   assign byteLane = bus.mem_rdata >> {heldAlu[1:0], 3'b000};
   assign halfLane = bus.mem_rdata >> {heldAlu[1], 4'b0000};

   // Load extension; unlisted type codes fall back to a full word
   always_comb begin
      ldData = bus.mem_rdata;
      case (heldLdtype)
         3'b000:  ldData = {{(XLEN-8){byteLane[7]}}, byteLane[7:0]};
         3'b100:  ldData = {{(XLEN-8){1'b0}}, byteLane[7:0]};
         3'b001:  ldData = {{(XLEN-16){halfLane[15]}}, halfLane[15:0]};
         3'b101:  ldData = {{(XLEN-16){1'b0}}, halfLane[15:0]};
         default: ldData = bus.mem_rdata;
      endcase
   end

   // Result select; forced to zero while empty so the write data never floats
   always_comb begin
      wrData = heldAlu;
      if (state == EMPTY)              wrData = '0;
      else if (heldWdsel == SEL_LOAD)  wrData = ldData;
      else if (heldWdsel == SEL_PC4)   wrData = heldPc + XLEN'(4);
      else                             wrData = heldAlu;
   end

   assign bus.stall_req = stallReq;
   assign bus.RFWr      = heldRfwr & (heldRd != 5'd0) & retire;
   assign bus.WrDtAdr   = heldRd;
   assign bus.WrDt      = wrData;
   assign bus.instret   = instretQ;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/PC+4/load results, late load
// back-pressure, write suppression, counter wrap and reset during a wait.
module tb_wb_stage;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   nChk = 0;
   int   nBad = 0;
   logic [31:0] expCnt;

   wb_stage_if #(.XLEN(32)) bus ();
   wb_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChk++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drv(input logic v, input logic rf, input logic [4:0] rd,
                      input logic [1:0] ws, input logic [2:0] lt,
                      input logic [31:0] alu, input logic [31:0] pc);
      bus.in_valid  = v;
      bus.in_rfwr   = rf;
      bus.in_rd     = rd;
      bus.in_wdsel  = ws;
      bus.in_ldtype = lt;
      bus.in_alu    = alu;
      bus.in_pc     = pc;
   endtask

   task automatic idle;
      drv(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
      bus.flush = 1'b0;
   endtask

   // Load-extension vectors: ldtype, low address bits, expected result
   logic [2:0]  ldT [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
   logic [1:0]  ldA [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
   logic [31:0] ldE [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                            32'h00007F01, 32'h80FF7F01};

   initial begin
      // Reset held with random inputs
      drv(1'b1, 1'b1, 5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom);
      bus.flush      = 1'($urandom);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      tick; tick;
      #1;
      chk("rst_rfwr",  32'(bus.RFWr), 32'd0);
      chk("rst_stall", 32'(bus.stall_req), 32'd0);
      chk("rst_cnt",   bus.instret, 32'd0);
      chk("rst_wrdt",  bus.WrDt, 32'd0);
      chk("rst_adr",   32'(bus.WrDtAdr), 32'd0);

      // First ALU op after release
      @(negedge clk);
      rst = 1'b1;
      bus.mem_rvalid = 1'b0;
      idle;
      drv(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h1234, 32'h40);
      tick;
      idle;
      #1;
      chk("alu_rfwr", 32'(bus.RFWr), 32'd1);
      chk("alu_adr",  32'(bus.WrDtAdr), 32'd5);
      chk("alu_wrdt", bus.WrDt, 32'h1234);
      tick;
      #1;
      chk("alu_cnt",   bus.instret, 32'd1);
      chk("empty_wr",  32'(bus.RFWr), 32'd0);
      chk("empty_dt",  bus.WrDt, 32'd0);
      expCnt = 32'd1;

      // Loads answered in their first WB cycle: no stall
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drv(1'b1, 1'b1, 5'd10, 2'b01, ldT[i], 32'h100 | 32'(ldA[i]), 32'h80);
         tick;
         idle;
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = 32'h80FF7F01;
         #1;
         chk($sformatf("ld%0d_stall", i), 32'(bus.stall_req), 32'd0);
         chk($sformatf("ld%0d_rfwr", i),  32'(bus.RFWr), 32'd1);
         chk($sformatf("ld%0d_data", i),  bus.WrDt, ldE[i]);
         tick;
         bus.mem_rvalid = 1'b0;
         expCnt++;
      end
      #1;
      chk("ld_cnt", bus.instret, expCnt);

      // Late response: three stall cycles, younger op must not overwrite
      @(negedge clk);
      drv(1'b1, 1'b1, 5'd7, 2'b01, 3'b010, 32'h200, 32'h90);
      tick;
      drv(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'hAAAA, 32'h94);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("late%0d_stall", k), 32'(bus.stall_req), 32'd1);
         chk($sformatf("late%0d_rfwr", k),  32'(bus.RFWr), 32'd0);
         chk($sformatf("late%0d_adr", k),   32'(bus.WrDtAdr), 32'd7);
         tick;
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEADBEEF;
      #1;
      chk("late_stall", 32'(bus.stall_req), 32'd0);
      chk("late_rfwr",  32'(bus.RFWr), 32'd1);
      chk("late_data",  bus.WrDt, 32'hDEADBEEF);
      chk("late_cnt0",  bus.instret, expCnt);
      tick;
      bus.mem_rvalid = 1'b0;
      idle;
      expCnt++;
      #1;
      chk("late_cnt1", bus.instret, expCnt);
      chk("next_adr",  32'(bus.WrDtAdr), 32'd9);
      chk("next_data", bus.WrDt, 32'hAAAA);
      tick;
      expCnt++;

      // rd=0: no write, still counts
      drv(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h55, 32'h98);
      tick;
      idle;
      #1;
      chk("x0_rfwr", 32'(bus.RFWr), 32'd0);
      tick;
      expCnt++;
      #1;
      chk("x0_cnt", bus.instret, expCnt);

      // Flush beats valid: bubble, no write, no count
      @(negedge clk);
      drv(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h77, 32'h9C);
      bus.flush = 1'b1;
      tick;
      idle;
      #1;
      chk("fl_rfwr", 32'(bus.RFWr), 32'd0);
      chk("fl_data", bus.WrDt, 32'd0);
      tick;
      #1;
      chk("fl_cnt", bus.instret, expCnt);

      // JAL at top of address space: PC+4 wraps to zero
      @(negedge clk);
      drv(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h1, 32'hFFFFFFFC);
      tick;
      idle;
      #1;
      chk("jal_rfwr", 32'(bus.RFWr), 32'd1);
      chk("jal_data", bus.WrDt, 32'h0);
      tick;
      expCnt++;
      #1;
      chk("jal_cnt", bus.instret, expCnt);

      // Counter wrap via backdoor preset
      @(negedge clk);
      force dut.instretQ = 32'hFFFFFFFF;
      #1;
      release dut.instretQ;
      drv(1'b1, 1'b1, 5'd2, 2'b00, 3'b000, 32'h3, 32'hA0);
      tick;
      idle;
      #1;
      chk("wrap_pre", bus.instret, 32'hFFFFFFFF);
      tick;
      #1;
      chk("wrap_cnt", bus.instret, 32'h0);

      // Reset in the middle of a wait discards the load
      @(negedge clk);
      drv(1'b1, 1'b1, 5'd4, 2'b01, 3'b010, 32'h300, 32'hA4);
      tick;
      idle;
      #1;
      chk("mw_stall", 32'(bus.stall_req), 32'd1);
      rst = 1'b0;
      #1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h12345678;
      #1;
      chk("mw_rfwr",  32'(bus.RFWr), 32'd0);
      chk("mw_stall0", 32'(bus.stall_req), 32'd0);
      chk("mw_cnt",   bus.instret, 32'd0);
      chk("mw_data",  bus.WrDt, 32'd0);
      tick;
      #1;
      chk("mw_cnt2",  bus.instret, 32'd0);
      bus.mem_rvalid = 1'b0;
      rst = 1'b1;

      $display("test done: total=%0d bad=%0d", nChk, nBad);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage pipelined CPU: the MEM/WB pipeline register plus the write-back logic that drives the register file's write port (RFWr, WrDtAdr, WrDt). The stage:
- selects the result source;
- sign/zero-extends load data;
- waits for a late data-memory read response;
- back-pressures the pipeline while waiting;
- counts retired instructions.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  MEM stage holds a valid instruction.
- in_rfwr  in  1  instruction writes a register.
- in_rd  in  5  destination register.
- in_wdsel  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- in_ldtype  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are treated as LW.
- in_alu  in  XLEN  ALU result; it is also the load address.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  inserts a bubble instead of capturing the MEM stage.
- mem_rvalid  in  1  data-memory read response valid (single-cycle pulse).
- mem_rdata  in  XLEN  raw aligned little-endian word.
- stall_req  out  1  freeze upstream stages this cycle.
- RFWr  out  1  register-file write enable.
- WrDtAdr  out  5  register-file write address.
- WrDt  out  XLEN  register-file write data.
- instret  out  32  count of retired instructions.

## Operation
- States:
  - EMPTY: no instruction held.
  - READY: holds a non-load, or a load with data available.
  - WAIT: holds a load whose response has not arrived.
- Capture:
  - On the rising edge with stall_req=0, the stage register loads the in_* fields.
  - Next state is EMPTY if in_valid=0 or flush=1.
  - Otherwise next state is WAIT if in_wdsel=01, else READY.
- WAIT:
  - stall_req=1, RFWr=0.
  - When mem_rvalid=1, the write is performed that same cycle from mem_rdata, stall_req drops to 0, and the next edge captures normally.
- READY: stall_req=0; the write is performed; the next edge captures.
- stall_req = (state==WAIT) & ~mem_rvalid. No other condition raises it.
- Write enable:
  - RFWr = held_rfwr & (WrDtAdr!=0) & (state==READY | (state==WAIT & mem_rvalid)).
  - WrDtAdr = held rd, always driven.
  - WrDt is don't-care when RFWr=0 but must be deterministic: 0 when EMPTY.
- Data select:
  - ALU: held alu.
  - PC+4: held pc + 4, modulo 2^XLEN.
  - Load: extended lane of mem_rdata.
- Load extension (low address bits a = held alu[1:0]):
  - LB/LBU: byte mem_rdata[8a+7:8a], sign- or zero-extended.
  - LH/LHU: half selected by a[1], sign- or zero-extended; a[0] is ignored.
  - LW: full word; a is ignored.
- instret:
  - Increments by 1 on each rising edge at which a held valid instruction leaves the stage: state READY, or state WAIT with mem_rvalid=1.
  - Counting is independent of rfwr, so stores and branches count.
  - Wraps from 0xFFFFFFFF to 0.
- Flush takes priority over in_valid. Flush during WAIT has no effect: flush only affects capture, and capture is blocked during WAIT.
- mem_rvalid while state is not WAIT is ignored.

## Timing
- Reset (rst=0): state EMPTY, held fields 0, instret 0, RFWr=0, WrDtAdr=0, WrDt=0, stall_req=0. Reset is effective immediately, not clock-gated.
- Reset asserted during WAIT discards the load: no write, no count.
- Latency: an instruction captured at edge N drives RFWr in cycle N..N+1. The register file commits at the following falling edge, so decode reads in that cycle see the new value.
- Load with the response in its first WB cycle: zero stall cycles.
- Load with the response k cycles late: exactly k cycles of stall_req=1.
- The outputs are combinational from the held state and the mem_rvalid/mem_rdata inputs; the in_* inputs do not feed the outputs combinationally.

## Test plan
- Reset: hold rst=0 with random inputs → RFWr=0, stall_req=0, instret=0, WrDt=0. Release and capture ALU op rd=5, alu=0x1234 → RFWr=1, WrDtAdr=5, WrDt=0x1234; instret=1 after the next edge.
- Load extension: mem_rdata=0x80FF7F01 with rvalid in the first cycle. Expected results:
  - LB a=3 → 0xFFFFFF80.
  - LBU a=3 → 0x00000080.
  - LH a=2 → 0xFFFF80FF.
  - LHU a=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Late response: LW rd=7, mem_rvalid arrives 3 cycles after capture → stall_req=1 for exactly 3 cycles; RFWr=1 only in the rvalid cycle; the held stage is not overwritten while stalled; instret increments once.
- Write suppression:
  - rd=0 with rfwr=1 → RFWr=0 and instret still increments.
  - flush=1 with in_valid=1 → state EMPTY, no write, no count.
  - JAL pc=0xFFFFFFFC, wdsel=10 → WrDt=0x00000000.
- Counter wrap and mid-wait reset:
  - Preset instret=0xFFFFFFFF via 2^32−1 retirements or backdoor force, then retire one → instret=0.
  - Assert rst during WAIT → no write; instret=0.
